// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state/quarter encodings and byte-size constant for the I2C master.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package i2c_pkg;

   typedef enum logic [3:0] {
      IDLE, START, ADDR, ACK1, WDATA, ACK2, RDATA, MNACK, STOP
   } state_t;

   typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quarter_t;

   localparam int         BITS_PER_BYTE = 8;
   localparam logic [2:0] LAST_BIT      = 3'(BITS_PER_BYTE - 1);

endpackage

// File: rtl/i2c_clk_gen.sv
// i2c_clk_gen: divides clk into SCL quarter-bits; one-cycle strobe on the last cycle of each quarter.
// Latency: first strobe CLK_DIV cycles after en rises; quarter index advances on the strobe.
// Backpressure: none; held at Q0 / count 0 whenever en is low.
module i2c_clk_gen
   import i2c_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     en,
   output logic     qend,
   output quarter_t quarter
);

   localparam int            CW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   quarter_t      quarter_q, quarter_d;

   // divider and quarter registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q     <= '0;
         quarter_q <= Q0;
      end else begin
         cnt_q     <= cnt_d;
         quarter_q <= quarter_d;
      end
   end

   // count while enabled, wrap at CLK_DIV-1 and step the quarter
   always_comb begin
      cnt_d     = cnt_q;
      quarter_d = quarter_q;
      qend      = 1'b0;
      if (!en) begin
         cnt_d     = '0;
         quarter_d = Q0;
      end else if (cnt_q == CNT_MAX) begin
         qend      = 1'b1;
         cnt_d     = '0;
         quarter_d = quarter_t'(quarter_q + 2'd1);
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   assign quarter = quarter_q;

endmodule

// File: rtl/i2c_master.sv
// i2c_master: single-byte I2C master (START, {addr,wr} LSB-first, data, ACK slots, STOP); I2C_MASTER_ACK_CHECK_EN enables NACK detect/abort.
// Latency: done pulses 1 + 20*4*CLK_DIV cycles after newd is accepted (11 bit periods when an address NACK aborts).
// Backpressure: newd accepted only in IDLE; requests while busy are dropped. SCL/SDA are registered (one clk behind the FSM).
module i2c_master
   import i2c_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       newd,
   input  logic       wr,
   input  logic [6:0] addr,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       busy,
   output logic       done,
   output logic       ack_err,
   output logic       scl,
   inout  wire        sda
);

`ifdef I2C_MASTER_ACK_CHECK_EN
   localparam bit ACK_CHECK = 1'b1;
`else
   localparam bit ACK_CHECK = 1'b0;
`endif

   state_t     state_q, state_d;
   quarter_t   quarter;
   logic       qend, bit_end, sample, mid, sda_in, abort;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] frame_q, frame_d, din_q, din_d, rx_q, rx_d, dout_q, dout_d;
   logic       busy_q, busy_d, done_q, done_d, ack_err_q, ack_err_d;
   logic       scl_q, scl_d, sda_low_q, sda_low_d;

   i2c_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
      .clk     (clk),
      .rst     (rst),
      .en      (state_q != IDLE),
      .qend    (qend),
      .quarter (quarter)
   );

   assign bit_end = qend && (quarter == Q3);
   assign sample  = qend && (quarter == Q1);
   assign mid     = (quarter == Q1) || (quarter == Q2);
   assign sda_in  = sda;
   // address NACK skips the data byte (only possible with ACK checking built in)
   assign abort   = ACK_CHECK && ack_err_q;

   // state register and all datapath/bus flops
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         frame_q   <= '0;
         din_q     <= '0;
         rx_q      <= '0;
         dout_q    <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ack_err_q <= 1'b0;
         scl_q     <= 1'b1;
         sda_low_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         frame_q   <= frame_d;
         din_q     <= din_d;
         rx_q      <= rx_d;
         dout_q    <= dout_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         ack_err_q <= ack_err_d;
         scl_q     <= scl_d;
         sda_low_q <= sda_low_d;
      end
   end

   // next state: advance only at the end of a bit period
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      case (state_q)
         IDLE:  if (newd) state_d = START;
         START: if (bit_end) state_d = ADDR;
         ADDR, WDATA, RDATA: begin
            if (bit_end) begin
               if (bit_cnt_q == LAST_BIT) begin
                  bit_cnt_d = '0;
                  state_d   = (state_q == ADDR)  ? ACK1 :
                              (state_q == WDATA) ? ACK2 : MNACK;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
         ACK1:        if (bit_end) state_d = abort ? STOP : (frame_q[0] ? WDATA : RDATA);
         ACK2, MNACK: if (bit_end) state_d = STOP;
         STOP:        if (bit_end) state_d = IDLE;
         default:     state_d = IDLE;
      endcase
   end

   // outputs: bus levels per quarter, request latching, ACK/read sampling, completion
   always_comb begin
      frame_d   = frame_q;
      din_d     = din_q;
      rx_d      = rx_q;
      dout_d    = dout_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      ack_err_d = ack_err_q;
      scl_d     = 1'b1;
      sda_low_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (newd) begin
               frame_d   = {addr, wr};
               din_d     = din;
               ack_err_d = 1'b0;
               busy_d    = 1'b1;
            end
         end
         START: begin
            scl_d     = (quarter != Q3);
            sda_low_d = (quarter != Q0);
         end
         ADDR: begin
            scl_d     = mid;
            sda_low_d = !frame_q[bit_cnt_q];
         end
         WDATA: begin
            scl_d     = mid;
            sda_low_d = !din_q[bit_cnt_q];
         end
         ACK1, ACK2: begin
            scl_d = mid;
            if (sample && sda_in && ACK_CHECK) ack_err_d = 1'b1;
         end
         RDATA: begin
            scl_d = mid;
            if (sample) rx_d = {sda_in, rx_q[7:1]};
         end
         MNACK: scl_d = mid;
         STOP: begin
            scl_d     = (quarter != Q0);
            sda_low_d = (quarter != Q3);
            if (bit_end) begin
               done_d = 1'b1;
               busy_d = 1'b0;
               if (!frame_q[0] && !abort) dout_d = rx_q;
            end
         end
         default: ;
      endcase
   end

   assign sda     = sda_low_q ? 1'b0 : 1'bz;
   assign scl     = scl_q;
   assign dout    = dout_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign ack_err = ack_err_q;

endmodule

// File: tb/tb_i2c_master.sv
`timescale 1ns/1ps
module tb_i2c_master;

   logic       clk  = 1'b0;
   logic       rst  = 1'b1;
   logic       newd = 1'b0;
   logic       wr   = 1'b0;
   logic [6:0] addr = '0;
   logic [7:0] din  = '0;
   logic [7:0] dout;
   logic       busy, done, ack_err, scl;
   wire        sda;
   logic       slv_low = 1'b0;

   assign sda = slv_low ? 1'b0 : 1'bz;
   pullup (sda);

   always #5 clk = ~clk;

   i2c_master #(.CLK_DIV(4)) dut (
      .clk(clk), .rst(rst), .newd(newd), .wr(wr), .addr(addr), .din(din),
      .dout(dout), .busy(busy), .done(done), .ack_err(ack_err), .scl(scl), .sda(sda)
   );

   int n_vec = 0;
   int n_bad = 0;

   // slave / bus monitor
   bit         cur_wr   = 1'b0;
   bit         cur_nack = 1'b0;
   logic [7:0] cur_rd   = '0;
   bit         in_frame = 1'b0;
   int         rises    = 0;
   int         n_start  = 0;
   int         n_stop   = 0;
   logic       rec [0:31];
   logic       prev_scl = 1'b1;
   logic       prev_sda = 1'b1;

   // slot n = number of SCL rises since START; 0..7 address, 8 ACK1, 9..16 data, 17 ACK2/MNACK
   function automatic logic slave_drive(input int n);
      if (n == 8) return !cur_nack;
      if (cur_wr && n == 17) return 1'b1;
      if (!cur_wr && n >= 9 && n <= 16) return !cur_rd[n-9];
      return 1'b0;
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         in_frame <= 1'b0;
         rises    <= 0;
         slv_low  <= 1'b0;
      end else if (scl && prev_scl && prev_sda && !sda) begin
         in_frame <= 1'b1;
         rises    <= 0;
         n_start  <= n_start + 1;
      end else if (in_frame && scl && prev_scl && !prev_sda && sda) begin
         in_frame <= 1'b0;
         n_stop   <= n_stop + 1;
      end else if (in_frame && scl && !prev_scl) begin
         if (rises < 32) rec[rises] <= sda;
         rises <= rises + 1;
      end else if (in_frame && !scl && prev_scl) begin
         slv_low <= slave_drive(rises);
      end
      prev_scl <= scl;
      prev_sda <= sda;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, exp);
      end
   endtask

   typedef struct {
      bit         wr;
      logic [6:0] addr;
      logic [7:0] din;
      bit         nack;
      logic [7:0] rd;
      int         lat;
      bit         err;
      logic [7:0] frame;
      logic [7:0] data;
      int         rises;
   } vec_t;

   vec_t vt [6];

   task automatic run_frame(input int idx, input bit launch, input bit hold, input int pulse_at);
      vec_t       v;
      int         lat;
      bit         got;
      int         s0;
      logic [7:0] fb, db;
      v        = vt[idx];
      cur_wr   = v.wr;
      cur_nack = v.nack;
      cur_rd   = v.rd;
      s0       = n_stop;
      if (launch) begin
         wr = v.wr; addr = v.addr; din = v.din; newd = 1'b1;
      end
      lat = 0;
      got = 1'b0;
      while (!got && lat < 2000) begin
         @(posedge clk); #1;
         lat++;
         if (!hold) begin
            newd = (pulse_at != 0) && (lat == pulse_at);
            if (lat == 1) begin addr = ~v.addr; din = ~v.din; end
         end
         if (done) got = 1'b1;
      end
      check("latency", lat, v.lat);
      check("ack_err", ack_err, v.err);
      check("busy_at_done", busy, 1'b0);
      for (int k = 0; k < 8; k++) fb[k] = rec[k];
      check("addr_frame", fb, v.frame);
      check("ack1_slot", rec[8], v.nack);
      check("scl_rises", rises, v.rises);
      check("stop_seen", n_stop - s0, 1);
      if (v.rises == 19) begin
         for (int k = 0; k < 8; k++) db[k] = rec[9+k];
         check("data_byte", db, v.data);
         check("slot17", rec[17], !v.wr);
         if (!v.wr) check("dout", dout, v.data);
      end
      if (!hold) begin
         @(posedge clk); #1;
         check("done_pulse", done, 1'b0);
      end
   endtask

   initial begin
      int n0;
      vt[0] = '{1'b1, 7'h12, 8'hA5, 1'b0, 8'h00, 321, 1'b0, 8'h25, 8'hA5, 19};
      vt[1] = '{1'b0, 7'h12, 8'h00, 1'b0, 8'h3C, 321, 1'b0, 8'h24, 8'h3C, 19};
      vt[2] = '{1'b1, 7'h7F, 8'h00, 1'b0, 8'h00, 321, 1'b0, 8'hFF, 8'h00, 19};
      vt[3] = '{1'b0, 7'h01, 8'h00, 1'b0, 8'hA5, 321, 1'b0, 8'h02, 8'hA5, 19};
`ifdef I2C_MASTER_ACK_CHECK_EN
      vt[4] = '{1'b1, 7'h12, 8'hA5, 1'b1, 8'h00, 177, 1'b1, 8'h25, 8'h00, 10};
`else
      vt[4] = '{1'b1, 7'h12, 8'hA5, 1'b1, 8'h00, 321, 1'b0, 8'h25, 8'hA5, 19};
`endif
      vt[5] = '{1'b0, 7'h55, 8'h00, 1'b0, 8'h81, 321, 1'b0, 8'hAA, 8'h81, 19};

      // reset state
      #2 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_scl", scl, 1'b1);
      check("rst_sda", sda, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_ack_err", ack_err, 1'b0);
      check("rst_dout", dout, 8'h00);
      rst = 1'b1;
      @(posedge clk); #1;

      // table of single transactions
      for (int i = 0; i < 6; i++) begin
         run_frame(i, 1'b1, 1'b0, 0);
         repeat (3) @(posedge clk);
         #1;
      end

      // newd pulsed mid-frame (with different inputs) is ignored
      run_frame(0, 1'b1, 1'b0, 100);
      repeat (3) @(posedge clk);
      #1;

      // newd held through done: second frame starts from the done cycle
      n0 = n_start;
      run_frame(2, 1'b1, 1'b1, 0);
      run_frame(2, 1'b0, 1'b0, 0);
      check("back_to_back_starts", n_start - n0, 2);
      repeat (3) @(posedge clk);
      #1;

      // reset during WDATA bit 3 (frame bit period 13, SCL high phase)
      cur_wr = 1'b1; cur_nack = 1'b0; cur_rd = 8'h00;
      wr = 1'b1; addr = 7'h12; din = 8'hA5; newd = 1'b1;
      for (int i = 0; i < 218; i++) begin
         @(posedge clk); #1;
         if (i == 0) newd = 1'b0;
      end
      check("pre_rst_scl", scl, 1'b1);
      check("pre_rst_sda", sda, 1'b0);
      check("pre_rst_busy", busy, 1'b1);
      #2 rst = 1'b0;
      #1;
      check("midrst_scl", scl, 1'b1);
      check("midrst_sda", sda, 1'b1);
      check("midrst_busy", busy, 1'b0);
      check("midrst_done", done, 1'b0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      run_frame(0, 1'b1, 1'b0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/i2c_master.md
# i2c_master

Single-byte I2C bus master: the initiating end for the team's `i2c_slave` memory. It generates SCL from the system clock and frames START, a 7-bit address plus R/W bit, one data byte, the ACK slots and STOP. It returns read data and ACK status to the host logic. It sits between the host/test logic and the shared SDA line.

## Interface
- `CLK_DIV`, default 4: `clk` cycles per SCL quarter-bit; legal range ≥ 2.
- `clk`  input  1  system clock; all logic on its rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `newd`  input  1  transaction request; sampled only in IDLE.
- `wr`  input  1  1 = write byte to slave, 0 = read byte from slave.
- `addr`  input  7  slave memory address.
- `din`  input  8  write data.
- `dout`  output  8  read data; valid from `done` until the next accepted `newd`.
- `busy`  output  1  transaction in progress.
- `done`  output  1  one-cycle pulse at transaction end.
- `ack_err`  output  1  slave NACKed; held until the next accepted `newd`.
- `scl`  output  1  bus clock.
- `sda`  inout  1  open-drain: driven 0 or released (`z`), never driven 1.

## Operation
- Reset values (immediate, asynchronous): `scl`=1, `sda` released, `busy`=0, `done`=0, `ack_err`=0, `dout`=0, state IDLE, all counters 0.
- IDLE → START on `newd`=1. The master latches `addr`, `wr` and `din`, clears `ack_err`, and sets `busy` in the next cycle.
- START: `sda` falls while `scl`=1, then `scl` falls. Takes one bit period.
- ADDR: 8 bits of the frame byte {`addr`,`wr`}. Bit 0 (=`wr`) is sent first, LSB-first throughout.
- ACK1: `sda` released, sampled. Next state is WDATA if `wr`=1 and RDATA if `wr`=0.
- WDATA: `din` sent LSB-first. Then ACK2: `sda` released, sampled. Then STOP.
- RDATA: 8 bits sampled and assembled LSB-first into a shift register. Then MNACK: `sda` released (NACK, single-byte read). Then STOP.
- STOP: `sda` low with `scl` low, `scl` rises, then `sda` is released while `scl`=1. At the end of STOP:
  - `dout` loads on a read.
  - `done` pulses.
  - `busy` clears.
  - Return to IDLE.
- Bit counter: 3 bits, 0..7. Wrap from 7 exits the byte state.
- `newd` while `busy`=1 is ignored. `newd` still high in the IDLE cycle after `done` starts a new transaction.

## Timing
- Each bit has 4 quarters of `CLK_DIV` cycles each. One bit period is 4·`CLK_DIV` clk cycles.
- Quarters: Q0 `scl`=0, with `sda` updated on entry; Q1 `scl`=1; Q2 `scl`=1; Q3 `scl`=0.
- `sda` is sampled on the last cycle of Q1.
- Full frame is 20 bit periods: START + 8 + ACK + 8 + ACK/NACK + STOP.
- `done` is asserted in the cycle after the final STOP quarter. `busy` falls in the same cycle.
- From `newd` accepted to `done` is 1 + 20·4·`CLK_DIV` cycles.
- Reset mid-frame: the bus is released immediately. No STOP is generated.

## Configuration
- `I2C_MASTER_ACK_CHECK_EN` defined:
  - A 1 sampled in ACK1 or ACK2 sets `ack_err`.
  - NACK in ACK1 goes directly to STOP, skipping the data byte. That frame is 11 bit periods.
  - On an aborted read, `dout` is unchanged.
- Not defined:
  - ACK slots are clocked but ignored.
  - `ack_err` is tied 0.
  - Every frame is 20 bit periods.

## Structure
- Package `i2c_pkg` holds:
  - state enum {IDLE, START, ADDR, ACK1, WDATA, ACK2, RDATA, MNACK, STOP};
  - quarter enum {Q0..Q3};
  - bit-count constant 8.
- Sub-module `i2c_clk_gen`:
  - contains the `CLK_DIV` counter (width $clog2(`CLK_DIV`));
  - outputs a one-cycle quarter-end strobe and a 2-bit quarter index;
  - is held in Q0 / count 0 while IDLE.
- The FSM advances only on the quarter-end strobe.

## Test plan
All scenarios use `CLK_DIV`=4, so one bit period is 16 clk cycles.
- Write: `addr`=7'h12, `wr`=1, `din`=8'hA5, slave ACKs → SDA bits after START are 1,0,1,0,0,1,0,0, then ACK, then 1,0,1,0,0,1,0,1, then ACK, then STOP. `done` comes 321 cycles after `newd`; `ack_err`=0.
- Read: `addr`=7'h12, `wr`=0, slave drives 8'h3C LSB-first → `dout`=8'h3C at `done`. `sda` is released in the 9th data slot; STOP follows.
- Macro defined, slave NACKs the address → `ack_err`=1, STOP immediately follows ACK1, no data clocks. `done` comes 177 cycles after `newd`.
- Macro undefined, same NACK → full 20-bit frame, `ack_err`=0.
- `newd` pulsed mid-frame → ignored. `newd` held high through `done` → second START begins after one IDLE cycle.
- `rst` low during WDATA bit 3 → same cycle: `scl`=1, `sda`=z, `busy`=0. After release, `newd` produces a clean full frame.
